// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command-bus decoder: re-encodes pin-level commands, tracks open rows per bank,
// schedules CL/CWL data-phase strobes and flags protocol errors. Optional macro: DDR4_DEC_TIMING_CHECK_EN.
module ddr4_cmd_decoder #(
  parameter int CL   = 16,
  parameter int CWL  = 12,
  parameter int TRCD = 16,
  parameter int TRP  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CKE,
  input  logic        CS_n,
  input  logic        ACT_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic [1:0]  BG,
  input  logic [1:0]  BA,
  input  logic [13:0] ADDR,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [31:0] cmd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_addr,
  output logic        wr_strobe,
  output logic [31:0] wr_addr,
  output logic        err_pulse,
  output logic [3:0]  err_status
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  // Packed address layout: COL[7:0], ROW[21:8], BANK[23:22], BG[25:24]
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 8;
  localparam int BANK_LSB = 22;
  localparam int BG_LSB   = 24;

  typedef enum logic [2:0] {
    DEC_NOP,
    DEC_ACT,
    DEC_PRE,
    DEC_RD,
    DEC_WR,
    DEC_BAD
  } dec_e;

  function automatic logic [31:0] pack_addr(input logic [1:0]  bg,
                                            input logic [1:0]  ba,
                                            input logic [13:0] row,
                                            input logic [7:0]  col);
    logic [31:0] p;
    p = '0;
    p[BG_LSB +: 2]   = bg;
    p[BANK_LSB +: 2] = ba;
    p[ROW_LSB +: 14] = row;
    p[COL_LSB +: 8]  = col;
    return p;
  endfunction

  dec_e        dec;
  logic [3:0]  bank;
  logic        timing_err;

  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic        err_pulse_q, err_pulse_d;
  logic [3:0]  err_status_q, err_status_d;
  logic [15:0] open_q, open_d;
  logic [13:0] row_q [16];
  logic [13:0] row_d [16];

  // Stage 0 is loaded on the command edge, so stage N becomes visible N edges later
  logic        rd_vld_pipe_q  [CL+1];
  logic        rd_vld_pipe_d  [CL+1];
  logic [31:0] rd_addr_pipe_q [CL+1];
  logic [31:0] rd_addr_pipe_d [CL+1];
  logic        wr_vld_pipe_q  [CWL+1];
  logic        wr_vld_pipe_d  [CWL+1];
  logic [31:0] wr_addr_pipe_q [CWL+1];
  logic [31:0] wr_addr_pipe_d [CWL+1];

  assign bank = {BG, BA};

  always_comb begin
    dec = DEC_NOP;
    if (!CKE || CS_n) begin
      dec = DEC_NOP;
    end else if (!ACT_n) begin
      dec = DEC_ACT;
    end else begin
      case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
        3'b010:  dec = DEC_PRE;
        3'b101:  dec = DEC_RD;
        3'b100:  dec = DEC_WR;
        3'b111:  dec = DEC_NOP;
        default: dec = DEC_BAD;
      endcase
    end
  end

`ifdef DDR4_DEC_TIMING_CHECK_EN
  localparam logic [7:0] TRCD_C = 8'(TRCD);
  localparam logic [7:0] TRP_C  = 8'(TRP);

  logic [7:0] act_cnt_q [16];
  logic [7:0] act_cnt_d [16];
  logic [7:0] pre_cnt_q [16];
  logic [7:0] pre_cnt_d [16];

  // Saturating since-ACT / since-PRE counters; a command restarts its own bank's counter at 0
  always_comb begin
    timing_err = 1'b0;
    for (int b = 0; b < 16; b++) begin
      act_cnt_d[b] = (act_cnt_q[b] == 8'hFF) ? 8'hFF : act_cnt_q[b] + 8'd1;
      pre_cnt_d[b] = (pre_cnt_q[b] == 8'hFF) ? 8'hFF : pre_cnt_q[b] + 8'd1;
    end
    case (dec)
      DEC_ACT: begin
        act_cnt_d[bank] = 8'd0;
        if (pre_cnt_q[bank] < TRP_C) timing_err = 1'b1;
      end
      DEC_PRE: pre_cnt_d[bank] = 8'd0;
      DEC_RD, DEC_WR: begin
        if (act_cnt_q[bank] < TRCD_C) timing_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 16; b++) begin
        act_cnt_q[b] <= 8'hFF;
        pre_cnt_q[b] <= 8'hFF;
      end
    end else begin
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end
`else
  assign timing_err = 1'b0;
`endif

  always_comb begin
    logic [3:0] err_new;
    logic       rd_push;
    logic       wr_push;
    err_new     = 4'b0000;
    rd_push     = 1'b0;
    wr_push     = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    cmd_addr_d  = '0;
    open_d      = open_q;
    row_d       = row_q;

    case (dec)
      DEC_ACT: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_ACT;
        cmd_addr_d  = pack_addr(BG, BA, ADDR, 8'h00);
        err_new[0]  = open_q[bank];
        open_d[bank] = 1'b1;
        row_d[bank]  = ADDR;
      end
      DEC_PRE: begin
        cmd_valid_d  = 1'b1;
        cmd_d        = CMD_PRE;
        cmd_addr_d   = pack_addr(BG, BA, 14'h0000, 8'h00);
        open_d[bank] = 1'b0;
      end
      DEC_RD, DEC_WR: begin
        cmd_valid_d = 1'b1;
        cmd_d       = (dec == DEC_RD) ? CMD_RD : CMD_WR;
        cmd_addr_d  = pack_addr(BG, BA, row_q[bank], ADDR[7:0]);
        err_new[1]  = ~open_q[bank];
        rd_push     = open_q[bank] && (dec == DEC_RD);
        wr_push     = open_q[bank] && (dec == DEC_WR);
      end
      DEC_BAD: err_new[2] = 1'b1;
      default: ;
    endcase

    err_new[3]   = timing_err;
    err_status_d = err_status_q | err_new;
    err_pulse_d  = |err_new;

    rd_vld_pipe_d[0]  = rd_push;
    rd_addr_pipe_d[0] = rd_push ? cmd_addr_d : 32'h0;
    for (int i = 1; i <= CL; i++) begin
      rd_vld_pipe_d[i]  = rd_vld_pipe_q[i-1];
      rd_addr_pipe_d[i] = rd_addr_pipe_q[i-1];
    end
    wr_vld_pipe_d[0]  = wr_push;
    wr_addr_pipe_d[0] = wr_push ? cmd_addr_d : 32'h0;
    for (int i = 1; i <= CWL; i++) begin
      wr_vld_pipe_d[i]  = wr_vld_pipe_q[i-1];
      wr_addr_pipe_d[i] = wr_addr_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_NOP;
      cmd_addr_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_status_q <= 4'b0000;
      open_q       <= '0;
      for (int b = 0; b < 16; b++) row_q[b] <= '0;
      for (int i = 0; i <= CL; i++) begin
        rd_vld_pipe_q[i]  <= 1'b0;
        rd_addr_pipe_q[i] <= '0;
      end
      for (int i = 0; i <= CWL; i++) begin
        wr_vld_pipe_q[i]  <= 1'b0;
        wr_addr_pipe_q[i] <= '0;
      end
    end else begin
      cmd_valid_q    <= cmd_valid_d;
      cmd_q          <= cmd_d;
      cmd_addr_q     <= cmd_addr_d;
      err_pulse_q    <= err_pulse_d;
      err_status_q   <= err_status_d;
      open_q         <= open_d;
      row_q          <= row_d;
      rd_vld_pipe_q  <= rd_vld_pipe_d;
      rd_addr_pipe_q <= rd_addr_pipe_d;
      wr_vld_pipe_q  <= wr_vld_pipe_d;
      wr_addr_pipe_q <= wr_addr_pipe_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign cmd_addr   = cmd_addr_q;
  assign err_pulse  = err_pulse_q;
  assign err_status = err_status_q;
  assign rd_valid   = rd_vld_pipe_q[CL];
  assign rd_addr    = rd_addr_pipe_q[CL];
  assign wr_strobe  = wr_vld_pipe_q[CWL];
  assign wr_addr    = wr_addr_pipe_q[CWL];

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed bench for ddr4_cmd_decoder; expected values hand-computed for the default
// address layout COL[7:0], ROW[21:8], BANK[23:22], BG[25:24].
module tb_ddr4_cmd_decoder;

  localparam int CL  = 16;
  localparam int CWL = 12;
`ifdef DDR4_DEC_TIMING_CHECK_EN
  localparam logic TC = 1'b1;
`else
  localparam logic TC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  BG, BA;
  logic [13:0] ADDR;
  logic        cmd_valid, rd_valid, wr_strobe, err_pulse;
  logic [2:0]  cmd;
  logic [31:0] cmd_addr, rd_addr, wr_addr;
  logic [3:0]  err_status;

  int vectors = 0;
  int miscompares = 0;

  ddr4_cmd_decoder #(.CL(CL), .CWL(CWL), .TRCD(16), .TRP(16)) dut (
    .clk(clk), .reset(reset),
    .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .BG(BG), .BA(BA), .ADDR(ADDR),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .err_pulse(err_pulse), .err_status(err_status)
  );

  always #5 clk = ~clk;

  // Drive pins, let one rising edge sample them, then settle 1ns past the edge
  task automatic applyStimulus(input logic cke, input logic cs_n, input logic act_n,
                               input logic ras, input logic cas, input logic we,
                               input logic [3:0] bank, input logic [13:0] addr);
    CKE = cke; CS_n = cs_n; ACT_n = act_n;
    RAS_n_A16 = ras; CAS_n_A15 = cas; WE_n_A14 = we;
    BG = bank[3:2]; BA = bank[1:0]; ADDR = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic doNop();                                        applyStimulus(1, 1, 1, 1, 1, 1, 4'd0, 14'h0);   endtask
  task automatic doAct(input logic [3:0] b, input logic [13:0] r); applyStimulus(1, 0, 0, 1, 1, 1, b, r);         endtask
  task automatic doPre(input logic [3:0] b);                     applyStimulus(1, 0, 1, 0, 1, 0, b, 14'h0);      endtask
  task automatic doRd(input logic [3:0] b, input logic [7:0] c);  applyStimulus(1, 0, 1, 1, 0, 1, b, {6'h0, c});  endtask
  task automatic doWr(input logic [3:0] b, input logic [7:0] c);  applyStimulus(1, 0, 1, 1, 0, 0, b, {6'h0, c});  endtask

  initial begin
    reset = 1'b1;
    doNop();
    doNop();
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_cmd_addr", cmd_addr, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_strobe", wr_strobe, 0);
    checkOutput("rst_err_pulse", err_pulse, 0);
    checkOutput("rst_err_status", err_status, 0);
    reset = 1'b0;
    doNop();

    $display("[TB] ACT bank 6 row 0x1ABC, RD col 0x3C twenty cycles later");
    doAct(4'd6, 14'h1ABC);
    checkOutput("act_cmd_valid", cmd_valid, 1);
    checkOutput("act_cmd", cmd, 1);
    checkOutput("act_cmd_addr", cmd_addr, 32'h019A_BC00);
    checkOutput("act_err_pulse", err_pulse, 0);
    doNop();
    checkOutput("act_pulse_width", cmd_valid, 0);
    for (int i = 0; i < 18; i++) doNop();
    doRd(4'd6, 8'h3C);
    checkOutput("rd_cmd_valid", cmd_valid, 1);
    checkOutput("rd_cmd", cmd, 3);
    checkOutput("rd_cmd_addr", cmd_addr, 32'h019A_BC3C);
    checkOutput("rd_valid_j0", rd_valid, 0);
    for (int j = 1; j <= CL + 1; j++) begin
      doNop();
      checkOutput($sformatf("rd_valid_j%0d", j), rd_valid, (j == CL));
      if (j == CL) checkOutput("rd_addr", rd_addr, 32'h019A_BC3C);
    end
    checkOutput("rd_err_status", err_status, 0);

    $display("[TB] WR to closed bank 5");
    doWr(4'd5, 8'h10);
    checkOutput("wrc_cmd_valid", cmd_valid, 1);
    checkOutput("wrc_cmd", cmd, 4);
    checkOutput("wrc_err_pulse", err_pulse, 1);
    checkOutput("wrc_err_status", err_status, 4'b0010);
    for (int j = 1; j <= CWL + 2; j++) begin
      doNop();
      checkOutput($sformatf("wrc_wr_strobe_j%0d", j), wr_strobe, 0);
      if (j == 1) checkOutput("wrc_err_pulse_drop", err_pulse, 0);
    end

    $display("[TB] ACT bank 5 row 0x55, WR col 0x10");
    doAct(4'd5, 14'h0055);
    for (int i = 0; i < 19; i++) doNop();
    doWr(4'd5, 8'h10);
    checkOutput("wr_cmd_addr", cmd_addr, 32'h0140_5510);
    checkOutput("wr_err_pulse", err_pulse, 0);
    for (int j = 1; j <= CWL + 1; j++) begin
      doNop();
      checkOutput($sformatf("wr_strobe_j%0d", j), wr_strobe, (j == CWL));
      if (j == CWL) checkOutput("wr_addr", wr_addr, 32'h0140_5510);
    end

    $display("[TB] double ACT then double PRE on bank 0");
    doAct(4'd0, 14'h0001);
    checkOutput("act0a_err_pulse", err_pulse, 0);
    doAct(4'd0, 14'h0002);
    checkOutput("act0b_cmd_valid", cmd_valid, 1);
    checkOutput("act0b_err_pulse", err_pulse, 1);
    checkOutput("act0b_err_status", err_status, 4'b0011);
    doPre(4'd0);
    checkOutput("pre0a_cmd", cmd, 2);
    checkOutput("pre0a_cmd_addr", cmd_addr, 0);
    checkOutput("pre0a_err_pulse", err_pulse, 0);
    doPre(4'd0);
    checkOutput("pre0b_cmd_valid", cmd_valid, 1);
    checkOutput("pre0b_err_pulse", err_pulse, 0);
    checkOutput("pre0b_err_status", err_status, 4'b0011);

    $display("[TB] four back-to-back RDs to bank 3");
    doAct(4'd3, 14'h0200);
    for (int i = 0; i < 19; i++) doNop();
    for (int j = 0; j <= CL + 4; j++) begin
      if (j < 4) doRd(4'd3, 8'(j));
      else doNop();
      checkOutput($sformatf("b2b_rd_valid_j%0d", j), rd_valid, (j >= CL && j < CL + 4));
      if (j >= CL && j < CL + 4)
        checkOutput($sformatf("b2b_rd_addr_j%0d", j), rd_addr, 32'h00C2_0000 + 32'(j - CL));
    end
    checkOutput("b2b_err_status", err_status, 4'b0011);

    $display("[TB] REF is unsupported, CKE low is ignored");
    applyStimulus(1, 0, 1, 0, 0, 1, 4'd0, 14'h0);
    checkOutput("ref_cmd_valid", cmd_valid, 0);
    checkOutput("ref_err_pulse", err_pulse, 1);
    checkOutput("ref_err_status", err_status, 4'b0111);
    applyStimulus(0, 0, 1, 1, 0, 1, 4'd3, 14'h0005);
    checkOutput("cke0_cmd_valid", cmd_valid, 0);
    checkOutput("cke0_err_pulse", err_pulse, 0);
    for (int j = 1; j <= CL + 1; j++) begin
      doNop();
      checkOutput($sformatf("cke0_rd_valid_j%0d", j), rd_valid, 0);
    end

    $display("[TB] RD five cycles after ACT on bank 9, then reset mid-latency");
    doAct(4'd9, 14'h0077);
    for (int i = 0; i < 4; i++) doNop();
    doRd(4'd9, 8'h05);
    checkOutput("trcd_cmd_valid", cmd_valid, 1);
    checkOutput("trcd_err_pulse", err_pulse, TC);
    checkOutput("trcd_err_status", err_status, {TC, 3'b111});
    for (int i = 0; i < 5; i++) doNop();
    reset = 1'b1;
    doNop();
    checkOutput("mid_rst_err_status", err_status, 0);
    checkOutput("mid_rst_cmd_valid", cmd_valid, 0);
    checkOutput("mid_rst_err_pulse", err_pulse, 0);
    reset = 1'b0;
    for (int j = 1; j <= CL; j++) begin
      doNop();
      checkOutput($sformatf("flush_rd_valid_j%0d", j), rd_valid, 0);
    end
    checkOutput("flush_err_status", err_status, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
